sysarr_gen: RTL and testbench

SYSARR_GEN -- requirements
Module: sysarr_gen

---
 rtl/sysarr_pkg.sv | 20 ++
 rtl/sysarr_gen_if.sv | 33 +++
 rtl/sys_pe.sv | 47 ++++
 rtl/sysarr_gen.sv | 208 ++++++++++++++++++++
 tb/tb_sysarr_gen.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysarr_pkg.sv
// Shared definitions for the sysarr_gen output-stationary systolic array.
// FSM encoding and default geometry live here.
package sysarr_pkg;

   localparam int N_DEF  = 4;
   localparam int DW_DEF = 16;
   localparam int AW_DEF = 40;
   localparam int KW_DEF = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FEED  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   // cycles needed for the last operand pair to reach the far corner PE
   function automatic int flush_len(input int n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/sysarr_gen_if.sv
// Control, operand and result handshake bundle for sysarr_gen.
interface sysarr_gen_if import sysarr_pkg::*; #(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int KW = KW_DEF
) ();

   logic                   start;
   logic [KW-1:0]          k_len;
   logic                   acc_keep;
   logic                   in_valid;
   logic                   in_ready;
   logic [N*DW-1:0]        a_col;
   logic [N*DW-1:0]        b_row;
   logic                   out_valid;
   logic                   out_ready;
   logic [$clog2(N)-1:0]   out_row;
   logic [N*AW-1:0]        out_data;
   logic                   busy;
   logic                   done;

   modport master (
      output start, k_len, acc_keep, in_valid, a_col, b_row, out_ready,
      input  in_ready, out_valid, out_row, out_data, busy, done
   );

   modport slave (
      input  start, k_len, acc_keep, in_valid, a_col, b_row, out_ready,
      output in_ready, out_valid, out_row, out_data, busy, done
   );

endinterface

// File: rtl/sys_pe.sv
// One multiply-accumulate cell: registers a rightward and b downward,
// accumulates the signed product in place.
module sys_pe import sysarr_pkg::*; #(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   output logic [DW-1:0] a_out,
   output logic [DW-1:0] b_out,
   output logic [AW-1:0] acc
);

   logic [DW-1:0]          a_q, a_d;
   logic [DW-1:0]          b_q, b_d;
   logic [AW-1:0]          acc_q, acc_d;
   logic signed [2*DW-1:0] prod;

   assign prod = (2*DW)'($signed(a_in)) * (2*DW)'($signed(b_in));

   // clr restarts the sum with this cycle's product so no operand is lost
   always_comb begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = (clr ? '0 : acc_q) + AW'(prod);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

   assign a_out = a_q;
   assign b_out = b_q;
   assign acc   = acc_q;

endmodule

// File: rtl/sysarr_gen.sv
// N x N output-stationary systolic matrix multiplier with skewed operand
// injection and row-by-row result drain.
module sysarr_gen import sysarr_pkg::*; #(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int KW = KW_DEF
) (
   input  logic         clk,
   input  logic         rst,
   sysarr_gen_if.slave  bus
);

   localparam int RW = $clog2(N);
   localparam int FW = $clog2(3 * N);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(flush_len(N) - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

   if (AW < 2 * DW) begin : g_chk
      $error("sysarr_gen: AW must be at least 2*DW");
   end

   logic [1:0]    state_q, state_d;
   logic [KW-1:0] klen_q, klen_d;
   logic [KW-1:0] feed_q, feed_d;
   logic          keep_q, keep_d;
   logic [FW-1:0] fl_q, fl_d;
   logic [RW-1:0] row_q, row_d;
   logic          done_q, done_d;

   logic is_idle, is_feed, is_flush, is_drain;
   logic start_ok, feed_fire, out_fire, clr;

   assign is_idle  = (state_q == S_IDLE);
   assign is_feed  = (state_q == S_FEED);
   assign is_flush = (state_q == S_FLUSH);
   assign is_drain = (state_q == S_DRAIN);

   assign start_ok  = is_idle && bus.start && (bus.k_len != '0);
   assign feed_fire = is_feed && bus.in_valid;
   assign out_fire  = is_drain && bus.out_ready;
   // clearing lags start by a cycle; it lands on the first accepted vector
   assign clr       = is_feed && (feed_q == '0) && !keep_q;

   always_comb begin
      state_d = state_q;
      klen_d  = klen_q;
      keep_d  = keep_q;
      feed_d  = feed_q;
      fl_d    = fl_q;
      row_d   = row_q;
      done_d  = 1'b0;
      unique case (1'b1)
         is_idle: begin
            if (start_ok) begin
               state_d = S_FEED;
               klen_d  = bus.k_len;
               keep_d  = bus.acc_keep;
               feed_d  = '0;
            end
         end
         is_feed: begin
            if (feed_fire) begin
               feed_d = feed_q + 1'b1;
               if (feed_q == klen_q - 1'b1) begin
                  state_d = S_FLUSH;
                  fl_d    = '0;
               end
            end
         end
         is_flush: begin
            if (fl_q == FLUSH_LAST) begin
               state_d = S_DRAIN;
               row_d   = '0;
            end else begin
               fl_d = fl_q + 1'b1;
            end
         end
         is_drain: begin
            if (out_fire) begin
               if (row_q == ROW_LAST) begin
                  state_d = S_IDLE;
                  row_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         klen_q  <= '0;
         keep_q  <= 1'b0;
         feed_q  <= '0;
         fl_q    <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         klen_q  <= klen_d;
         keep_q  <= keep_d;
         feed_q  <= feed_d;
         fl_q    <= fl_d;
         row_q   <= row_d;
         done_q  <= done_d;
      end
   end

   logic [N-1:0][DW-1:0] a_inj, b_inj;
   logic [DW-1:0]        a_sk [N];
   logic [DW-1:0]        b_sk [N];

   assign a_inj = feed_fire ? bus.a_col : '0;
   assign b_inj = feed_fire ? bus.b_row : '0;

   // lane i waits i cycles so operands meet on the anti-diagonal
   for (genvar i = 0; i < N; i++) begin : g_skew
      if (i == 0) begin : g_direct
         assign a_sk[0] = a_inj[0];
         assign b_sk[0] = b_inj[0];
      end else begin : g_sr
         logic [i-1:0][DW-1:0] a_q, a_d, b_q, b_d;
         always_comb begin
            a_d    = '0;
            b_d    = '0;
            a_d[0] = a_inj[i];
            b_d[0] = b_inj[i];
            for (int s = 1; s < i; s++) begin
               a_d[s] = a_q[s-1];
               b_d[s] = b_q[s-1];
            end
         end
         always_ff @(posedge clk) begin
            if (rst || start_ok) begin
               a_q <= '0;
               b_q <= '0;
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
         assign a_sk[i] = a_q[i-1];
         assign b_sk[i] = b_q[i-1];
      end
   end

   logic [DW-1:0] a_w   [N][N];
   logic [DW-1:0] b_w   [N][N];
   logic [AW-1:0] acc_w [N][N];

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [DW-1:0] a_o, b_o;
         if (j == 0) begin : g_ain
            assign a_w[i][0] = a_sk[i];
         end
         if (i == 0) begin : g_bin
            assign b_w[0][j] = b_sk[j];
         end
         sys_pe #(.DW(DW), .AW(AW)) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .a_in  (a_w[i][j]),
            .b_in  (b_w[i][j]),
            .a_out (a_o),
            .b_out (b_o),
            .acc   (acc_w[i][j])
         );
         if (j < N - 1) begin : g_aright
            assign a_w[i][j+1] = a_o;
         end else begin : g_aedge
            logic [DW-1:0] a_unused;
            assign a_unused = a_o;
         end
         if (i < N - 1) begin : g_bdown
            assign b_w[i+1][j] = b_o;
         end else begin : g_bedge
            logic [DW-1:0] b_unused;
            assign b_unused = b_o;
         end
      end
   end

   logic [N-1:0][AW-1:0] row_data;

   always_comb begin
      row_data = '0;
      if (is_drain) begin
         for (int j = 0; j < N; j++) begin
            row_data[j] = acc_w[row_q][j];
         end
      end
   end

   assign bus.in_ready  = is_feed;
   assign bus.out_valid = is_drain;
   assign bus.out_row   = row_q;
   assign bus.out_data  = row_data;
   assign bus.busy      = !is_idle;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_sysarr_gen.sv
// Randomized bench for sysarr_gen against a plain matrix-product model.
module tb_sysarr_gen;
   import sysarr_pkg::*;

   localparam int N    = 4;
   localparam int DW   = 16;
   localparam int AW   = 40;
   localparam int KW   = 8;
   localparam int RW   = $clog2(N);
   localparam int KMAX = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sysarr_gen_if #(.N(N), .DW(DW), .AW(AW), .KW(KW)) bus ();

   sysarr_gen #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic signed [DW-1:0] ma [N][KMAX];
   logic signed [DW-1:0] mb [KMAX][N];
   longint               ref_c [N][N];

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_ref();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            ref_c[i][j] = 0;
   endtask

   task automatic model_pass(input int k, input bit keep);
      if (!keep) clear_ref();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            for (int kk = 0; kk < k; kk++)
               ref_c[i][j] += longint'(ma[i][kk]) * longint'(mb[kk][j]);
   endtask

   task automatic fill_rand(input int k);
      for (int kk = 0; kk < k; kk++)
         for (int i = 0; i < N; i++) begin
            ma[i][kk] = DW'($urandom);
            mb[kk][i] = DW'($urandom);
         end
   endtask

   task automatic fill_const(input int k, input logic signed [DW-1:0] v);
      for (int kk = 0; kk < k; kk++)
         for (int i = 0; i < N; i++) begin
            ma[i][kk] = v;
            mb[kk][i] = v;
         end
   endtask

   function automatic logic [N*AW-1:0] exp_row(input int r);
      logic [N*AW-1:0] e;
      for (int j = 0; j < N; j++) e[j*AW +: AW] = AW'(ref_c[r][j]);
      return e;
   endfunction

   task automatic drive_vec(input int kk);
      logic [N*DW-1:0] av, bv;
      for (int i = 0; i < N; i++) begin
         av[i*DW +: DW] = ma[i][kk];
         bv[i*DW +: DW] = mb[kk][i];
      end
      bus.a_col = av;
      bus.b_row = bv;
   endtask

   // bmode: 0 no bubbles, 1 alternate, 2 random
   task automatic run_pass(input int k, input bit keep, input int bmode,
                           input int stall_row, input int stall_len,
                           input bit drain_start, input int exp_lat);
      int c1, c2, kk, guard;
      bit v, tog;
      logic [N*AW-1:0] snap, ex;
      model_pass(k, keep);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.k_len    = KW'(k);
      bus.acc_keep = keep;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.acc_keep = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL feed_entry in_ready=%b busy=%b want 1 1",
                  bus.in_ready, bus.busy);
      end
      kk = 0; guard = 0; tog = 1'b1; c1 = 0;
      while (kk < k && guard < 1000) begin
         if (bus.in_ready === 1'b1) begin
            case (bmode)
               1:       v = tog;
               2:       v = 1'($urandom_range(0, 1));
               default: v = 1'b1;
            endcase
            tog = ~tog;
            if (v) begin
               drive_vec(kk);
               bus.in_valid = 1'b1;
               if (kk == 0) c1 = cyc;
               kk++;
            end else begin
               bus.in_valid = 1'b0;
               bus.a_col    = {$urandom, $urandom};
               bus.b_row    = {$urandom, $urandom};
            end
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (kk != k) begin
         failures++;
         $display("FAIL feed_count accepted=%0d want %0d", kk, k);
      end
      guard = 0;
      while (bus.out_valid !== 1'b1 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL drain_timeout out_valid=%b want 1", bus.out_valid);
         return;
      end
      c2 = cyc;
      if (exp_lat >= 0) begin
         checks++;
         if (c2 - c1 != exp_lat) begin
            failures++;
            $display("FAIL latency got=%0d want %0d", c2 - c1, exp_lat);
         end
      end
      if (drain_start) begin
         bus.start     = 1'b1;
         bus.k_len     = KW'(5);
         bus.out_ready = 1'b0;
         @(negedge clk);
         bus.start = 1'b0;
         checks++;
         if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1 ||
             bus.in_ready !== 1'b0 || bus.out_row !== RW'(0)) begin
            failures++;
            $display("FAIL drain_start busy=%b ov=%b ir=%b row=%0d want 1 1 0 0",
                     bus.busy, bus.out_valid, bus.in_ready, bus.out_row);
         end
      end
      for (int r = 0; r < N; r++) begin
         ex = exp_row(r);
         if (r == stall_row) begin
            bus.out_ready = 1'b0;
            snap = bus.out_data;
            repeat (stall_len) @(negedge clk);
            checks++;
            if (bus.out_data !== snap || bus.out_row !== RW'(r)) begin
               failures++;
               $display("FAIL stall_hold row=%0d data=%h want row %0d data %h",
                        bus.out_row, bus.out_data, r, snap);
            end
         end
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_row !== RW'(r)) begin
            failures++;
            $display("FAIL row_index valid=%b row=%0d want 1 %0d",
                     bus.out_valid, bus.out_row, r);
         end
         checks++;
         if (bus.out_data !== ex) begin
            failures++;
            $display("FAIL row_data r=%0d got=%h want %h", r, bus.out_data, ex);
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse done=%b busy=%b want 1 0", bus.done, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL done_width done=%b want 0", bus.done);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy, bus.done,
           bus.out_row, bus.out_data} !== '0) begin
         failures++;
         $display("FAIL %s ir=%b ov=%b busy=%b done=%b row=%0d data=%h want all 0",
                  tag, bus.in_ready, bus.out_valid, bus.busy, bus.done,
                  bus.out_row, bus.out_data);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_outputs");
      rst = 1'b0;
      clear_ref();
      @(negedge clk);
      check_idle_outputs("idle_after_reset");
   endtask

   task automatic test_zero_start();
      bus.start = 1'b1;
      bus.k_len = '0;
      @(negedge clk);
      bus.start = 1'b0;
      check_idle_outputs("zero_klen_start");
      @(negedge clk);
      check_idle_outputs("zero_klen_later");
   endtask

   task automatic test_identity();
      for (int kk = 0; kk < 4; kk++)
         for (int i = 0; i < N; i++) begin
            ma[i][kk] = (i == kk) ? DW'(1) : DW'(0);
            mb[kk][i] = DW'(4 * kk + i);
         end
      run_pass(4, 1'b0, 0, -1, 0, 1'b0, 14);
   endtask

   task automatic test_min_operands();
      fill_const(4, DW'(1 << (DW - 1)));
      run_pass(4, 1'b0, 0, -1, 0, 1'b0, 14);
   endtask

   task automatic test_stall();
      fill_rand(6);
      run_pass(6, 1'b0, 0, -1, 0, 1'b0, 6 + 3 * N - 2);
      run_pass(6, 1'b0, 1, 1, 3, 1'b0, -1);
   endtask

   task automatic test_accumulate();
      fill_const(2, DW'(1));
      run_pass(2, 1'b0, 0, -1, 0, 1'b0, 2 + 3 * N - 2);
      run_pass(2, 1'b1, 0, -1, 0, 1'b0, -1);
      run_pass(2, 1'b0, 0, -1, 0, 1'b0, -1);
   endtask

   task automatic test_mid_reset();
      fill_rand(8);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.k_len    = KW'(8);
      bus.acc_keep = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      for (int kk = 0; kk < 2; kk++) begin
         drive_vec(kk);
         bus.in_valid = 1'b1;
         @(negedge clk);
      end
      rst          = 1'b1;
      bus.start    = 1'b1;
      drive_vec(2);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check_idle_outputs("mid_reset");
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      clear_ref();
      @(negedge clk);
      check_idle_outputs("mid_reset_after");
      fill_rand(5);
      run_pass(5, 1'b1, 0, -1, 0, 1'b0, 5 + 3 * N - 2);
   endtask

   task automatic test_drain_start();
      fill_rand(3);
      run_pass(3, 1'b0, 0, -1, 0, 1'b1, 3 + 3 * N - 2);
   endtask

   task automatic test_back_to_back();
      int k, sr;
      fill_rand(1);
      run_pass(1, 1'b0, 0, -1, 0, 1'b0, 1 + 3 * N - 2);
      for (int p = 0; p < 5; p++) begin
         k  = $urandom_range(1, KMAX);
         sr = $urandom_range(0, N);
         fill_rand(k);
         run_pass(k, 1'($urandom_range(0, 1)), 2, (sr == N) ? -1 : sr,
                  $urandom_range(1, 4), 1'b0, -1);
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.k_len     = '0;
      bus.acc_keep  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a_col     = '0;
      bus.b_row     = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_zero_start();
      test_identity();
      test_min_operands();
      test_stall();
      test_accumulate();
      test_mid_reset();
      test_drain_start();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
